// File: rtl/j1_uart_io_if.sv
// j1_uart_io_if: J1 CPU IO bus between the CPU (master) and the UART peripheral (slave).
interface j1_uart_io_if;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [15:0] io_dout;
    logic [15:0] io_din;
    logic        interrupt_request;
    modport master (output io_rd, io_wr, io_addr, io_dout, input io_din, interrupt_request);
    modport slave  (input io_rd, io_wr, io_addr, io_dout, output io_din, interrupt_request);
endinterface

// File: rtl/j1_uart_io.sv
// j1_uart_io: J1 IO-mapped UART with a TX shifter, mid-bit sampling RX and an RX byte FIFO.
module j1_uart_io #(
    parameter int CLKDIV   = 104,
    parameter int FIFOBITS = 4
) (
    input  logic        clk,
    input  logic        resetq,
    j1_uart_io_if.slave bus,
    input  logic        uart_rx,
    output logic        uart_tx
);
    localparam int CW = $clog2(CLKDIV);
    localparam int PW = FIFOBITS + 1;
    localparam logic [CW-1:0] BIT_END  = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKDIV / 2 - 1);
    localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;

    logic sel_data, sel_status, sel_irqen, wr_status;
    assign sel_data   = bus.io_addr == 16'h1000;
    assign sel_status = bus.io_addr == 16'h2000;
    assign sel_irqen  = bus.io_addr == 16'h4000;
    assign wr_status  = bus.io_wr && sel_status;

    logic [1:0]    tx_st_q, tx_st_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_sr_q, tx_sr_d;
    logic          tx_q, tx_d, tx_busy, tx_tick;
    assign tx_busy = tx_st_q != S_IDLE;
    assign tx_tick = tx_cnt_q == BIT_END;

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_bit_d = tx_bit_q;
        tx_sr_d  = tx_sr_q;
        tx_d     = tx_q;
        tx_cnt_d = (!tx_busy || tx_tick) ? '0 : tx_cnt_q + 1'b1;
        case (tx_st_q)
            S_IDLE: if (bus.io_wr && sel_data) begin
                tx_st_d = S_START;
                tx_sr_d = bus.io_dout[7:0];
                tx_d    = 1'b0;
            end
            S_START: if (tx_tick) begin
                tx_st_d  = S_DATA;
                tx_bit_d = '0;
                tx_d     = tx_sr_q[0];
                tx_sr_d  = tx_sr_q >> 1;
            end
            S_DATA: if (tx_tick) begin
                tx_bit_d = tx_bit_q + 1'b1;
                tx_d     = tx_bit_q == 3'd7 ? 1'b1 : tx_sr_q[0];
                tx_sr_d  = tx_sr_q >> 1;
                tx_st_d  = tx_bit_q == 3'd7 ? S_STOP : S_DATA;
            end
            default: if (tx_tick) tx_st_d = S_IDLE;
        endcase
    end

    // rx_prev_q holds the previous synchronized sample so only a fresh 1->0 edge starts a frame
    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic [1:0]    rx_st_q, rx_st_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sr_q, rx_sr_d;
    logic          rx_tick, push_req, ferr_set;
    assign rx_tick = rx_cnt_q == (rx_st_q == S_START ? HALF_END : BIT_END);

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_bit_d = rx_bit_q;
        rx_sr_d  = rx_sr_q;
        push_req = 1'b0;
        ferr_set = 1'b0;
        rx_cnt_d = (rx_st_q == S_IDLE || rx_tick) ? '0 : rx_cnt_q + 1'b1;
        case (rx_st_q)
            S_IDLE: if (rx_prev_q && !rx_s2_q) rx_st_d = S_START;
            S_START: if (rx_tick) begin
                rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
                rx_bit_d = '0;
            end
            S_DATA: if (rx_tick) begin
                rx_sr_d  = {rx_s2_q, rx_sr_q[7:1]};
                rx_bit_d = rx_bit_q + 1'b1;
                rx_st_d  = rx_bit_q == 3'd7 ? S_STOP : S_DATA;
            end
            default: if (rx_tick) begin
                rx_st_d  = S_IDLE;
                push_req = rx_s2_q;
                ferr_set = !rx_s2_q;
            end
        endcase
    end

    // when full, a same-cycle pop frees the very slot the push lands in
    logic [7:0]    mem_q [0:(1 << FIFOBITS) - 1];
    logic [PW-1:0] wp_q, rp_q, count;
    logic          rx_avail, rx_full, pop, push, ovr_set;
    logic          ovr_q, ferr_q, ie_q, irq_q;
    assign count    = wp_q - rp_q;
    assign rx_avail = count != '0;
    assign rx_full  = count == PW'(1 << FIFOBITS);
    assign pop      = bus.io_rd && sel_data && rx_avail;
    assign push     = push_req && (!rx_full || pop);
    assign ovr_set  = push_req && rx_full && !pop;

    assign bus.io_din = sel_data   ? {8'h00, rx_avail ? mem_q[rp_q[FIFOBITS-1:0]] : 8'h00} :
                        sel_status ? {11'b0, rx_full, ferr_q, ovr_q, rx_avail, tx_busy} :
                        sel_irqen  ? {15'b0, ie_q} : 16'h0000;
    assign bus.interrupt_request = irq_q;
    assign uart_tx = tx_q;

    always_ff @(posedge clk or negedge resetq)
        if (!resetq) begin
            tx_st_q   <= S_IDLE;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_sr_q   <= '0;
            tx_q      <= 1'b1;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            rx_st_q   <= S_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sr_q   <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
            ie_q      <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            tx_st_q   <= tx_st_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_bit_q  <= tx_bit_d;
            tx_sr_q   <= tx_sr_d;
            tx_q      <= tx_d;
            rx_s1_q   <= uart_rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            rx_st_q   <= rx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_bit_q  <= rx_bit_d;
            rx_sr_q   <= rx_sr_d;
            wp_q      <= push ? wp_q + 1'b1 : wp_q;
            rp_q      <= pop ? rp_q + 1'b1 : rp_q;
            ovr_q     <= ovr_set || (ovr_q && !(wr_status && bus.io_dout[2]));
            ferr_q    <= ferr_set || (ferr_q && !(wr_status && bus.io_dout[3]));
            ie_q      <= (bus.io_wr && sel_irqen) ? bus.io_dout[0] : ie_q;
            irq_q     <= ie_q && rx_avail;
        end

    always_ff @(posedge clk)
        if (push) mem_q[wp_q[FIFOBITS-1:0]] <= rx_sr_q;
endmodule

// File: tb/tb_j1_uart_io.sv
// tb_j1_uart_io: random-stimulus bench for j1_uart_io against a queue-based UART/FIFO model.
module tb_j1_uart_io;
    localparam int CDIV  = 4;
    localparam int FB    = 2;
    localparam int DEPTH = 1 << FB;
    localparam int FLEN  = 10 * CDIV;

    logic clk = 1'b0, resetq = 1'b0, uart_rx = 1'b1, uart_tx;
    int checks = 0, errors = 0;
    logic [7:0] mq[$];
    logic m_ovr = 1'b0, m_ferr = 1'b0, m_ie = 1'b0;
    int t_av, t_full, t_irq;

    j1_uart_io_if bus();
    j1_uart_io #(.CLKDIV(CDIV), .FIFOBITS(FB)) dut (
        .clk(clk), .resetq(resetq), .bus(bus), .uart_rx(uart_rx), .uart_tx(uart_tx));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] m_status();
        return {11'b0, mq.size() == DEPTH, m_ferr, m_ovr, mq.size() != 0, 1'b0};
    endfunction

    function automatic void m_frame(input logic [7:0] b, input logic stop);
        if (!stop) m_ferr = 1'b1;
        else if (mq.size() == DEPTH) m_ovr = 1'b1;
        else mq.push_back(b);
    endfunction

    task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk); bus.io_wr = 1'b1; bus.io_addr = a; bus.io_dout = d;
        @(negedge clk); bus.io_wr = 1'b0; bus.io_addr = 16'h2000;
    endtask

    task automatic cpu_rd(input logic [15:0] a, output logic [15:0] v);
        @(negedge clk); bus.io_rd = 1'b1; bus.io_addr = a; #1 v = bus.io_din;
        @(negedge clk); bus.io_rd = 1'b0; bus.io_addr = 16'h2000;
    endtask

    task automatic peek(input logic [15:0] a, output logic [15:0] v);
        bus.io_addr = a; #1 v = bus.io_din;
    endtask

    task automatic rd_data_chk();
        logic [15:0] e, v;
        e = mq.size() != 0 ? {8'h00, mq[0]} : 16'h0000;
        cpu_rd(16'h1000, v);
        if (mq.size() != 0) void'(mq.pop_front());
        chk("data", v, e);
    endtask

    // one frame per call; bit k of the line is {1, b, 0}[k / CDIV]
    task automatic tx_check(input logic [7:0] b, input logic dup, input logic [7:0] b2);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        @(negedge clk); bus.io_wr = 1'b1; bus.io_addr = 16'h1000; bus.io_dout = {8'h00, b};
        for (int k = 0; k <= FLEN; k++) begin
            @(negedge clk);
            if (k == 0 && dup) bus.io_dout = {8'h00, b2};
            else begin bus.io_wr = 1'b0; bus.io_addr = 16'h2000; end
            #1;
            chk("tx_bit", uart_tx, k < FLEN ? fr[k / CDIV] : 1'b1);
            if (!(k == 0 && dup)) chk("tx_busy", bus.io_din[0], k < FLEN);
        end
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop, input int pop_at, output logic [15:0] pv);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        t_av = -1; t_full = -1; t_irq = -1; pv = 'x;
        for (int c = 0; c < FLEN + 8; c++) begin
            @(negedge clk);
            uart_rx = c < FLEN ? fr[c / CDIV] : 1'b1;
            bus.io_rd = c == pop_at;
            bus.io_addr = c == pop_at ? 16'h1000 : 16'h2000;
            #1;
            if (c == pop_at) pv = bus.io_din;
            else begin
                if (t_av < 0 && bus.io_din[1]) t_av = c;
                if (t_full < 0 && bus.io_din[4]) t_full = c;
            end
            if (t_irq < 0 && bus.interrupt_request) t_irq = c;
        end
        @(negedge clk); bus.io_rd = 1'b0; bus.io_addr = 16'h2000;
    endtask

    initial begin
        logic [15:0] v;
        logic [7:0] b;
        logic s;
        int cal;
        bus.io_rd = 1'b0; bus.io_wr = 1'b0; bus.io_addr = 16'h2000; bus.io_dout = 16'h0000;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tx", uart_tx, 1'b1);
        chk("rst_irq", bus.interrupt_request, 1'b0);
        chk("rst_status", bus.io_din, 16'h0000);
        resetq = 1'b1;

        tx_check(8'hA5, 1'b0, 8'h00);
        tx_check(8'h42, 1'b1, 8'h43);
        repeat (2) tx_check(8'($urandom), 1'b0, 8'h00);

        cpu_wr(16'h4000, 16'h0001); m_ie = 1'b1;
        peek(16'h4000, v); chk("irqen", v, 16'h0001);
        rx_send(8'h3C, 1'b1, -1, v); m_frame(8'h3C, 1'b1);
        chk("irq_lat", 16'(t_irq - t_av), 16'h0001);
        peek(16'h2000, v); chk("status_3c", v, m_status());
        rd_data_chk();
        #1 chk("irq_pop0", bus.interrupt_request, 1'b1);
        @(negedge clk); #1 chk("irq_pop1", bus.interrupt_request, 1'b0);

        cal = -1;
        for (int i = 1; i <= 5; i++) begin
            rx_send(8'(i), 1'b1, -1, v); m_frame(8'(i), 1'b1);
            if (i == 4) cal = t_full;
        end
        peek(16'h2000, v); chk("status_ovr", v, 16'h0016);
        chk("status_model", v, m_status());
        chk("irq_full", bus.interrupt_request, 1'b1);
        repeat (5) rd_data_chk();

        cpu_wr(16'h2000, 16'h0004); m_ovr = 1'b0;
        peek(16'h2000, v); chk("ovr_clr", v, m_status());
        chk("cal", 16'(cal >= 0), 16'h0001);
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            rx_send(b, 1'b1, i == 4 ? cal - 1 : -1, v);
            if (i == 4) chk("pop_same", v, {8'h00, mq.pop_front()});
            m_frame(b, 1'b1);
            peek(16'h2000, v); chk("status_fill", v, m_status());
        end
        chk("no_ovr", v, 16'h0012);
        repeat (4) rd_data_chk();

        rx_send(8'h5A, 1'b0, -1, v); m_frame(8'h5A, 1'b0);
        peek(16'h2000, v); chk("ferr", v, 16'h0008);
        cpu_wr(16'h2000, 16'h0008); m_ferr = 1'b0;
        peek(16'h2000, v); chk("ferr_clr", v, 16'h0000);

        @(negedge clk); uart_rx = 1'b0;
        @(negedge clk); uart_rx = 1'b1;
        repeat (FLEN + 8) @(negedge clk);
        peek(16'h2000, v); chk("glitch", v, m_status());

        cpu_wr(16'h4001, {15'b0, !m_ie});
        peek(16'h4000, v); chk("unmapped_wr", v, {15'b0, m_ie});
        peek(16'h1001, v); chk("unmapped_rd", v, 16'h0000);

        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            s = $urandom_range(0, 3) != 0;
            rx_send(b, s, -1, v); m_frame(b, s);
            peek(16'h2000, v); chk("rand_status", v, m_status());
            chk("rand_irq", bus.interrupt_request, m_ie && mq.size() != 0);
            if ($urandom_range(0, 1) == 1) rd_data_chk();
            if ($urandom_range(0, 2) == 0) begin cpu_wr(16'h2000, 16'h000C); m_ovr = 1'b0; m_ferr = 1'b0; end
            if ($urandom_range(0, 3) == 0) begin cpu_wr(16'h4000, {15'b0, !m_ie}); m_ie = !m_ie; end
        end

        cpu_wr(16'h1000, 16'h0000);
        repeat (14) @(negedge clk);
        #1 chk("tx_mid", uart_tx, 1'b0);
        chk("tx_mid_busy", bus.io_din[0], 1'b1);
        resetq = 1'b0;
        #1 chk("rst_mid_tx", uart_tx, 1'b1);
        chk("rst_mid_status", bus.io_din, 16'h0000);
        chk("rst_mid_irq", bus.interrupt_request, 1'b0);
        @(negedge clk); resetq = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
